// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
// cpu_core : multi-cycle 6502-subset core (load/transfer/inc/dec/logic/adc/sbc)
// Rev 1.0
// ============================================================================
module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic        clk_out,
  output logic [7:0]  a_out,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic [7:0]  opcode_out,
  output logic [15:0] pc_out,
  output logic [3:0]  opcode_state_out,
  output logic [7:0]  alu_opcode_out,
  output logic [7:0]  alu_out_out,
  output logic        alu_cout_out
);

  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_OPER_LO = 4'd2;
  localparam logic [3:0] ST_OPER_HI = 4'd3;
  localparam logic [3:0] ST_READ    = 4'd4;
  localparam logic [3:0] ST_EXEC    = 4'd5;

  localparam logic [2:0] MODE_IMP = 3'd0;
  localparam logic [2:0] MODE_IMM = 3'd1;
  localparam logic [2:0] MODE_ZP  = 3'd2;
  localparam logic [2:0] MODE_ZPX = 3'd3;
  localparam logic [2:0] MODE_ABS = 3'd4;

  localparam logic [7:0] ALU_PASS = 8'd0;
  localparam logic [7:0] ALU_ADD  = 8'd1;
  localparam logic [7:0] ALU_SUB  = 8'd2;
  localparam logic [7:0] ALU_AND  = 8'd3;
  localparam logic [7:0] ALU_EOR  = 8'd4;
  localparam logic [7:0] ALU_OR   = 8'd5;
  localparam logic [7:0] ALU_INC  = 8'd6;
  localparam logic [7:0] ALU_DEC  = 8'd7;

  localparam logic [1:0] DST_NONE = 2'd0;
  localparam logic [1:0] DST_A    = 2'd1;
  localparam logic [1:0] DST_X    = 2'd2;
  localparam logic [1:0] DST_Y    = 2'd3;

  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_A   = 2'd1;
  localparam logic [1:0] SRC_X   = 2'd2;
  localparam logic [1:0] SRC_Y   = 2'd3;

  logic [3:0]  state;
  logic [15:0] pc;
  logic [7:0]  a, x, y, opcode, operand, alu_op;
  logic        c_flag, z_flag, n_flag;
  logic [2:0]  cur_mode;
  logic [1:0]  dst, src;
  logic [7:0]  rhs, alu_res, zpx_lo;
  logic        alu_carry;

  function automatic logic [2:0] mode_of(input logic [7:0] op);
    case (op)
      8'hA9, 8'hA2, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h09: mode_of = MODE_IMM;
      8'hA5:                                           mode_of = MODE_ZP;
      8'hB5:                                           mode_of = MODE_ZPX;
      8'hAD:                                           mode_of = MODE_ABS;
      default:                                         mode_of = MODE_IMP;
    endcase
  endfunction

  function automatic logic [7:0] alu_of(input logic [7:0] op);
    case (op)
      8'h69:        alu_of = ALU_ADD;
      8'hE9:        alu_of = ALU_SUB;
      8'h29:        alu_of = ALU_AND;
      8'h49:        alu_of = ALU_EOR;
      8'h09:        alu_of = ALU_OR;
      8'hE8, 8'hC8: alu_of = ALU_INC;
      8'hCA, 8'h88: alu_of = ALU_DEC;
      default:      alu_of = ALU_PASS;
    endcase
  endfunction

  assign cur_mode = mode_of(opcode);
  assign zpx_lo   = din + x;

  // Destination register and right-hand ALU source for the latched opcode
  always_comb begin
    dst = DST_NONE;
    src = SRC_MEM;
    case (opcode)
      8'hA9, 8'hA5, 8'hB5, 8'hAD,
      8'h69, 8'hE9, 8'h29, 8'h49, 8'h09: dst = DST_A;
      8'hA2: dst = DST_X;
      8'hAA: begin dst = DST_X; src = SRC_A; end
      8'hA8: begin dst = DST_Y; src = SRC_A; end
      8'h8A: begin dst = DST_A; src = SRC_X; end
      8'h98: begin dst = DST_A; src = SRC_Y; end
      8'hE8, 8'hCA: begin dst = DST_X; src = SRC_X; end
      8'hC8, 8'h88: begin dst = DST_Y; src = SRC_Y; end
      default: ;
    endcase
  end

  always_comb begin
    case (src)
      SRC_A:   rhs = a;
      SRC_X:   rhs = x;
      SRC_Y:   rhs = y;
      default: rhs = operand;
    endcase
  end

  always_comb begin
    alu_res   = rhs;
    alu_carry = c_flag;
    case (alu_op)
      ALU_ADD: {alu_carry, alu_res} = {1'b0, a} + {1'b0, rhs} + {8'h00, c_flag};
      ALU_SUB: {alu_carry, alu_res} = {1'b0, a} + {1'b0, ~rhs} + {8'h00, c_flag};
      ALU_AND: alu_res = a & rhs;
      ALU_EOR: alu_res = a ^ rhs;
      ALU_OR:  alu_res = a | rhs;
      ALU_INC: alu_res = rhs + 8'd1;
      ALU_DEC: alu_res = rhs - 8'd1;
      default: alu_res = rhs;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      addr    <= RESET_PC;
      a       <= 8'h00;
      x       <= 8'h00;
      y       <= 8'h00;
      opcode  <= 8'h00;
      operand <= 8'h00;
      alu_op  <= ALU_PASS;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          opcode <= din;
          alu_op <= alu_of(din);
          pc     <= pc + 16'd1;
          addr   <= pc + 16'd1;
          state  <= (mode_of(din) == MODE_IMP) ? ST_EXEC : ST_OPER_LO;
        end
        ST_OPER_LO: begin
          operand <= din;
          pc      <= pc + 16'd1;
          case (cur_mode)
            MODE_IMM: state <= ST_EXEC;
            MODE_ZP:  begin addr <= {8'h00, din};    state <= ST_READ; end
            MODE_ZPX: begin addr <= {8'h00, zpx_lo}; state <= ST_READ; end
            default:  begin addr <= pc + 16'd1;      state <= ST_OPER_HI; end
          endcase
        end
        ST_OPER_HI: begin
          // Low byte already sits in operand; form the absolute address directly
          pc    <= pc + 16'd1;
          addr  <= {din, operand};
          state <= ST_READ;
        end
        ST_READ: begin
          operand <= din;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          case (dst)
            DST_A:   a <= alu_res;
            DST_X:   x <= alu_res;
            DST_Y:   y <= alu_res;
            default: ;
          endcase
          if (dst != DST_NONE) begin
            z_flag <= (alu_res == 8'h00);
            n_flag <= alu_res[7];
          end
          if (alu_op == ALU_ADD || alu_op == ALU_SUB) c_flag <= alu_carry;
          else if (opcode == 8'h38) c_flag <= 1'b1;
          else if (opcode == 8'h18) c_flag <= 1'b0;
          addr  <= pc;
          state <= ST_FETCH;
        end
        default: begin
          addr  <= pc;
          state <= ST_FETCH;
        end
      endcase
    end
  end

  assign clk_out          = clk;
  assign a_out            = a;
  assign x_out            = x;
  assign y_out            = y;
  assign opcode_out       = opcode;
  assign pc_out           = pc;
  assign opcode_state_out = state;
  assign alu_opcode_out   = alu_op;
  assign alu_out_out      = alu_res;
  assign alu_cout_out     = c_flag;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// tb_cpu_core : random programs checked against an instruction-level model,
// plus literal expectations for a directed prologue and reset behaviour.
module tb_cpu_core;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din;
  logic [15:0] addr, pc_out;
  logic        clk_out, alu_cout_out;
  logic [7:0]  a_out, x_out, y_out, opcode_out, alu_opcode_out, alu_out_out;
  logic [3:0]  opcode_state_out;

  logic [7:0] mem [0:65535];
  assign din = mem[addr];

  always #5 clk = ~clk;

  cpu_core #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .clk_out(clk_out),
    .a_out(a_out), .x_out(x_out), .y_out(y_out), .opcode_out(opcode_out),
    .pc_out(pc_out), .opcode_state_out(opcode_state_out),
    .alu_opcode_out(alu_opcode_out), .alu_out_out(alu_out_out),
    .alu_cout_out(alu_cout_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ad;
    logic        ca;
  } step_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        c;
    logic [3:0]  lat;
  } lit_t;

  // Architectural model
  logic [7:0]  m_a, m_x, m_y, m_op, m_aop, m_res;
  logic        m_c, m_rv;
  logic [15:0] m_pc;
  int          m_lat;
  step_t       q[$];
  logic        run   = 1'b0;
  logic        first = 1'b1;
  lit_t        lits [24];
  logic [7:0]  ops  [20];
  logic [7:0]  prog [37];

  function automatic step_t mk(input logic [3:0] st, input logic [15:0] ad, input logic ca);
    step_t e;
    e.st = st; e.ad = ad; e.ca = ca;
    return e;
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_c = 1'b0;
    m_pc = 16'h0000; m_lat = 0; first = 1'b1;
    q.delete();
  endtask

  task automatic model_step();
    logic [7:0]  op, b1, b2, m, zl;
    logic [15:0] p1, p2, ea;
    int          mode, s;
    p1 = m_pc + 16'd1;
    p2 = m_pc + 16'd2;
    op = mem[m_pc]; b1 = mem[p1]; b2 = mem[p2];
    case (op)
      8'hA9, 8'hA2, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h09: mode = 1;
      8'hA5:   mode = 2;
      8'hB5:   mode = 3;
      8'hAD:   mode = 4;
      default: mode = 0;
    endcase
    q.delete();
    if (mode != 0) q.push_back(mk(4'd2, p1, 1'b1));
    if (mode == 4) q.push_back(mk(4'd3, p2, 1'b1));
    zl = b1 + m_x;
    case (mode)
      2:       ea = {8'h00, b1};
      3:       ea = {8'h00, zl};
      default: ea = {b2, b1};
    endcase
    if (mode >= 2) begin
      q.push_back(mk(4'd4, ea, 1'b1));
      m = mem[ea];
    end else begin
      m = b1;
    end
    q.push_back(mk(4'd5, 16'h0000, 1'b0));
    m_lat = q.size() + 1;
    m_op = op; m_aop = 8'd0; m_rv = 1'b1;
    case (op)
      8'hA9, 8'hA5, 8'hB5, 8'hAD: m_a = m;
      8'hA2: m_x = m;
      8'h69: begin
        s = int'(m_a) + int'(m) + int'(m_c);
        m_c = (s > 255); m_a = 8'(s); m_aop = 8'd1;
      end
      8'hE9: begin
        s = int'(m_a) - int'(m) - (1 - int'(m_c));
        m_c = (s >= 0); m_a = 8'(s); m_aop = 8'd2;
      end
      8'h29: begin m_a = m_a & m; m_aop = 8'd3; end
      8'h49: begin m_a = m_a ^ m; m_aop = 8'd4; end
      8'h09: begin m_a = m_a | m; m_aop = 8'd5; end
      8'hAA: m_x = m_a;
      8'hA8: m_y = m_a;
      8'h8A: m_a = m_x;
      8'h98: m_a = m_y;
      8'hE8: begin m_x = m_x + 8'd1; m_aop = 8'd6; end
      8'hC8: begin m_y = m_y + 8'd1; m_aop = 8'd6; end
      8'hCA: begin m_x = m_x - 8'd1; m_aop = 8'd7; end
      8'h88: begin m_y = m_y - 8'd1; m_aop = 8'd7; end
      8'h38: begin m_c = 1'b1; m_rv = 1'b0; end
      8'h18: begin m_c = 1'b0; m_rv = 1'b0; end
      default: m_rv = 1'b0;
    endcase
    case (op)
      8'hA2, 8'hAA, 8'hE8, 8'hCA: m_res = m_x;
      8'hA8, 8'hC8, 8'h88:        m_res = m_y;
      default:                    m_res = m_a;
    endcase
    m_pc = m_pc + 16'(1 + ((mode == 0) ? 0 : ((mode == 4) ? 2 : 1)));
  endtask

  // Per-cycle compare: expected state/address sequence, then architectural state at each fetch
  step_t cur;
  always @(negedge clk) begin
    if (run) begin
      if (q.size() != 0) begin
        cur = q.pop_front();
        chk("state", 32'(opcode_state_out), 32'(cur.st));
        if (cur.ca) chk("addr", 32'(addr), 32'(cur.ad));
        if (cur.st == 4'd5) begin
          chk("opcode", 32'(opcode_out), 32'(m_op));
          chk("alu_op", 32'(alu_opcode_out), 32'(m_aop));
          if (m_rv) chk("alu_out", 32'(alu_out_out), 32'(m_res));
        end
      end else begin
        chk("fetch_state", 32'(opcode_state_out), 32'd1);
        chk("fetch_addr", 32'(addr), 32'(m_pc));
        chk("pc", 32'(pc_out), 32'(m_pc));
        chk("a", 32'(a_out), 32'(m_a));
        chk("x", 32'(x_out), 32'(m_x));
        chk("y", 32'(y_out), 32'(m_y));
        chk("c", 32'(alu_cout_out), 32'(m_c));
        if (!first) begin
          for (int i = 0; i < 24; i++) begin
            if (lits[i].pc == m_pc) begin
              chk("lit_a", 32'(a_out), 32'(lits[i].a));
              chk("lit_x", 32'(x_out), 32'(lits[i].x));
              chk("lit_y", 32'(y_out), 32'(lits[i].y));
              chk("lit_c", 32'(alu_cout_out), 32'(lits[i].c));
              chk("lit_cycles", 32'(m_lat), 32'(lits[i].lat));
            end
          end
        end
        first = 1'b0;
        model_step();
      end
    end
  end

  task automatic do_reset();
    run = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_a", 32'(a_out), 32'h0);
    chk("rst_x", 32'(x_out), 32'h0);
    chk("rst_y", 32'(y_out), 32'h0);
    chk("rst_c", 32'(alu_cout_out), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_state", 32'(opcode_state_out), 32'd1);
    chk("rst_opcode", 32'(opcode_out), 32'h0);
    chk("rst_alu_op", 32'(alu_opcode_out), 32'h0);
    chk("clk_out", 32'(clk_out), 32'(clk));
    repeat (2) @(posedge clk);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    run = 1'b1;
  endtask

  initial begin
    logic found;
    lits = '{
      '{16'h02, 8'h03, 8'h00, 8'h00, 1'b0, 4'd3},
      '{16'h03, 8'h03, 8'h00, 8'h00, 1'b1, 4'd2},
      '{16'h05, 8'h01, 8'h00, 8'h00, 1'b1, 4'd3},
      '{16'h06, 8'h01, 8'h00, 8'h00, 1'b0, 4'd2},
      '{16'h08, 8'h05, 8'h00, 8'h00, 1'b0, 4'd3},
      '{16'h0A, 8'h05, 8'h00, 8'h00, 1'b0, 4'd3},
      '{16'h0C, 8'h03, 8'h00, 8'h00, 1'b0, 4'd3},
      '{16'h0E, 8'h07, 8'h00, 8'h00, 1'b0, 4'd3},
      '{16'h0F, 8'h07, 8'h07, 8'h00, 1'b0, 4'd2},
      '{16'h10, 8'h07, 8'h07, 8'h07, 1'b0, 4'd2},
      '{16'h12, 8'h07, 8'h15, 8'h07, 1'b0, 4'd3},
      '{16'h13, 8'h15, 8'h15, 8'h07, 1'b0, 4'd2},
      '{16'h14, 8'h07, 8'h15, 8'h07, 1'b0, 4'd2},
      '{16'h15, 8'h07, 8'h16, 8'h07, 1'b0, 4'd2},
      '{16'h16, 8'h07, 8'h16, 8'h08, 1'b0, 4'd2},
      '{16'h17, 8'h07, 8'h15, 8'h08, 1'b0, 4'd2},
      '{16'h18, 8'h07, 8'h15, 8'h07, 1'b0, 4'd2},
      '{16'h1A, 8'h07, 8'hFF, 8'h07, 1'b0, 4'd3},
      '{16'h1B, 8'h07, 8'h00, 8'h07, 1'b0, 4'd2},
      '{16'h1D, 8'h03, 8'h00, 8'h07, 1'b0, 4'd4},
      '{16'h1F, 8'h03, 8'h15, 8'h07, 1'b0, 4'd3},
      '{16'h21, 8'hCA, 8'h15, 8'h07, 1'b0, 4'd4},
      '{16'h24, 8'h03, 8'h15, 8'h07, 1'b0, 4'd5},
      '{16'h25, 8'h03, 8'h15, 8'h07, 1'b0, 4'd2}
    };
    ops = '{8'hA9, 8'hA5, 8'hB5, 8'hAD, 8'hA2, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h09,
            8'h38, 8'h18, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hE8, 8'hC8, 8'hCA, 8'h88};
    prog = '{8'hA9, 8'h03, 8'h38, 8'hE9, 8'h02, 8'h18, 8'h69, 8'h04, 8'h29, 8'h05,
             8'h49, 8'h06, 8'h09, 8'h07, 8'hAA, 8'hA8, 8'hA2, 8'h15, 8'h8A, 8'h98,
             8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hA2, 8'hFF, 8'hE8, 8'hA5, 8'h01, 8'hA2,
             8'h15, 8'hB5, 8'h01, 8'hAD, 8'h01, 8'h00, 8'hFE};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 37; i++) mem[i] = prog[i];
    for (int p = 16'h25; p < 16'h400; p++)
      if ($urandom_range(0, 9) < 7) mem[p] = ops[$urandom_range(0, 19)];

    model_reset();
    #2;
    do_reset();
    for (int i = 0; i < 6000 && m_pc < 16'h0380; i++) @(posedge clk);
    chk("progress", 32'(m_pc >= 16'h0380), 32'd1);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 80)) @(posedge clk);
      #2;
      do_reset();
    end

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      if (opcode_state_out == 4'd2 && opcode_out == 8'h69) found = 1'b1;
    end
    chk("adc_found", 32'(found), 32'd1);
    do_reset();

    repeat (200) @(posedge clk);
    #2;
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
